// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 10-bit signed ALU.
// Fetches 16-bit instructions, keeps a 4-entry register file, feeds the ALU
// during EXEC, writes the result back and latches the s/g flags. Conditional
// jumps test the latched flags. Every instruction takes exactly three cycles
// (FETCH, DECODE, EXEC).
//
// Instruction memory interface: a fixed-latency request, not a valid/ready
// pair. imem_rd is high for exactly one cycle (FETCH) with imem_addr = pc;
// the memory returns imem_rdata on the next cycle, which is captured in
// DECODE. There is no back-pressure; the memory must always answer in one
// cycle.
module alu_sequencer #(
  parameter int PC_W = 7,
  parameter int DW   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [4:0]      alu_opcode,
  output logic [DW-1:0]   alu_op1,
  output logic [DW-1:0]   alu_op2,
  input  logic [DW-1:0]   alu_res,
  input  logic            alu_s,
  input  logic            alu_g,
  output logic            busy,
  output logic            halted,
  output logic            err,
  input  logic [1:0]      dbg_sel,
  output logic [DW-1:0]   dbg_data,
  output logic [2:0]      dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LDI   = 5'b00001;
  localparam logic [4:0] OP_JMP   = 5'b00010;
  localparam logic [4:0] OP_JS    = 5'b00011;
  localparam logic [4:0] OP_JG    = 5'b00100;
  localparam logic [4:0] OP_DEC   = 5'b00101;
  localparam logic [4:0] OP_DECI  = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_XORI  = 5'b01000;
  localparam logic [4:0] OP_NAND  = 5'b01001;
  localparam logic [4:0] OP_NANDI = 5'b01010;
  localparam logic [4:0] OP_ROT   = 5'b01011;
  localparam logic [4:0] OP_ROTI  = 5'b01100;
  localparam logic [4:0] OP_INC   = 5'b10011;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [DW-1:0]   rf_q [4];
  logic [DW-1:0]   rf_d [4];
  logic            s_q, s_d;
  logic            g_q, g_d;

  // Instruction fields, always decoded from the held instruction register.
  logic [4:0]      op;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic [6:0]      imm;
  logic [DW-1:0]   imm_sext;
  logic [PC_W-1:0] jump_tgt;
  logic            is_alu_reg;
  logic            is_alu_imm;
  logic            is_alu;
  logic            exec_alu;

  // Field extraction and opcode classification.
  always_comb begin
    op         = ir_q[15:11];
    rd         = ir_q[10:9];
    rs         = ir_q[8:7];
    imm        = ir_q[6:0];
    imm_sext   = DW'($signed(imm));
    jump_tgt   = PC_W'(imm);
    is_alu_reg = (op == OP_DEC) || (op == OP_XOR) || (op == OP_NAND) ||
                 (op == OP_ROT) || (op == OP_INC);
    is_alu_imm = (op == OP_DECI) || (op == OP_XORI) || (op == OP_NANDI) ||
                 (op == OP_ROTI);
    is_alu     = is_alu_reg || is_alu_imm;
    exec_alu   = (state_q == ST_EXEC) && is_alu;
  end

  // ALU-facing outputs are held at zero except during EXEC of an ALU opcode,
  // so the ALU is quiet and its result is never looked at otherwise.
  always_comb begin
    alu_opcode = exec_alu ? op : 5'b00000;
    alu_op1    = exec_alu ? rf_q[rd] : '0;
    alu_op2    = '0;
    if (exec_alu) alu_op2 = is_alu_imm ? imm_sext : rf_q[rs];
  end

  // Status, fetch strobe and debug views, all decoded from the current state.
  always_comb begin
    busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
    halted    = (state_q == ST_HALT);
    err       = (state_q == ST_ERR);
    imem_rd   = (state_q == ST_FETCH);
    imem_addr = (state_q == ST_FETCH) ? pc_q : '0;
    dbg_data  = rf_q[dbg_sel];
    dbg_state = state_q;
  end

  // Next-state, write-back, flag and pc update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    s_d     = s_q;
    g_d     = g_q;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        // Registers and flags survive a restart; only the pc is rewound.
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = imem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (is_alu) begin
          rf_d[rd] = alu_res;
          s_d      = alu_s;
          g_d      = alu_g;
        end else begin
          case (op)
            OP_NOP: ;
            OP_LDI: rf_d[rd] = imm_sext;
            OP_JMP: pc_d = jump_tgt;
            OP_JS:  if (s_q) pc_d = jump_tgt;
            OP_JG:  if (g_q) pc_d = jump_tgt;
            OP_HALT: begin
              state_d = ST_HALT;
              pc_d    = pc_q;
            end
            default: begin
              state_d = ST_ERR;
              pc_d    = pc_q;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; an asynchronous reset drops any write-back in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      s_q     <= 1'b0;
      g_q     <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      s_q     <= s_d;
      g_q     <= g_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction memory model, behavioural 10-bit ALU,
// instruction-level reference model feeding fetch/ALU expected queues, a
// table of single-operation vectors and hand-written multi-cycle sequences.
module tb_alu_sequencer;

  localparam int PC_W = 7;
  localparam int DW   = 10;

  localparam logic [4:0] O_NOP = 5'd0,  O_LDI = 5'd1,  O_JMP = 5'd2,  O_JS = 5'd3;
  localparam logic [4:0] O_JG = 5'd4,   O_DEC = 5'd5,  O_DECI = 5'd6, O_XOR = 5'd7;
  localparam logic [4:0] O_XORI = 5'd8, O_NAND = 5'd9, O_NANDI = 5'd10, O_ROT = 5'd11;
  localparam logic [4:0] O_ROTI = 5'd12, O_INC = 5'd19, O_HALT = 5'd31;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic [4:0]      alu_opcode;
  logic [DW-1:0]   alu_op1, alu_op2, alu_res;
  logic            alu_s, alu_g;
  logic            busy, halted, err;
  logic [1:0]      dbg_sel;
  logic [DW-1:0]   dbg_data;
  logic [2:0]      dbg_state;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(PC_W), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_s(alu_s), .alu_g(alu_g),
    .busy(busy), .halted(halted), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ---------------- environment models ----------------
  logic [15:0] imem [128];

  always @(posedge clk) if (imem_rd) imem_rdata <= imem[imem_addr];

  // Behavioural ALU. Unknown opcodes (including the idle 00000) return a
  // garbage pattern with both flags set so a stray sample is visible.
  function automatic logic [11:0] alu_fn(input logic [4:0] op, input logic [9:0] a,
                                         input logic [9:0] b);
    logic [9:0] r;
    logic       g;
    g = ($signed(a) > $signed(b));
    case (op)
      O_DEC, O_DECI:   r = a - 10'd1;
      O_XOR, O_XORI:   r = a ^ b;
      O_NAND, O_NANDI: r = ~(a & b);
      O_ROT, O_ROTI:   r = {a[8:0], a[9]};
      O_INC:           r = a + 10'd1;
      default: return {1'b1, 1'b1, 10'h2AA};
    endcase
    return {r[9], g, r};
  endfunction

  always_comb {alu_s, alu_g, alu_res} = alu_fn(alu_opcode, alu_op1, alu_op2);

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
    return {op[4:0], rd[1:0], rs[1:0], imm[6:0]};
  endfunction

  function automatic logic [9:0] sx7(input logic [6:0] v);
    return {{3{v[6]}}, v};
  endfunction

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [6:0]  exp_fetch_q [$];
  logic [24:0] exp_alu_q [$];
  logic [9:0]  m_r [4];
  logic        m_s, m_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: walks imem from pc 0, pushes the expected
  // fetch addresses and ALU transactions, updates the model register state.
  task automatic model_run(input int limit, output int steps, output int fin);
    logic [6:0]  pc, npc, imm;
    logic [4:0]  op;
    logic [1:0]  rd, rs;
    logic [9:0]  b;
    logic [11:0] sgr;
    logic        use_alu;
    pc = 7'd0; steps = 0; fin = 0;
    while (fin == 0 && steps < limit) begin
      exp_fetch_q.push_back(pc);
      {op, rd, rs, imm} = imem[pc];
      steps++;
      npc = pc + 7'd1;
      use_alu = 1'b0;
      b = 10'd0;
      case (op)
        O_NOP: ;
        O_LDI: m_r[rd] = sx7(imm);
        O_JMP: npc = imm;
        O_JS:  if (m_s) npc = imm;
        O_JG:  if (m_g) npc = imm;
        O_HALT: fin = 1;
        O_DEC, O_XOR, O_NAND, O_ROT, O_INC: begin use_alu = 1'b1; b = m_r[rs]; end
        O_DECI, O_XORI, O_NANDI, O_ROTI:    begin use_alu = 1'b1; b = sx7(imm); end
        default: fin = 2;
      endcase
      if (use_alu) begin
        exp_alu_q.push_back({op, m_r[rd], b});
        sgr = alu_fn(op, m_r[rd], b);
        m_r[rd] = sgr[9:0];
        m_s = sgr[11];
        m_g = sgr[10];
      end
      pc = npc;
    end
  endtask

  // Monitor: compare every fetch and every ALU issue against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_rd) begin
        if (exp_fetch_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL fetch_extra: got addr %0d expected no fetch", imem_addr);
        end else check("fetch_addr", 32'(imem_addr), 32'(exp_fetch_q.pop_front()));
      end
      if (alu_opcode != 5'd0) begin
        if (exp_alu_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL alu_extra: got op %0h expected no ALU issue", alu_opcode);
        end else check("alu_issue", 32'({alu_opcode, alu_op1, alu_op2}),
                       32'(exp_alu_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = enc(O_HALT, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_r[i] = 10'd0;
    m_s = 1'b0; m_g = 1'b0;
    exp_fetch_q.delete(); exp_alu_q.delete();
  endtask

  task automatic read_reg(input int idx, output logic [9:0] v);
    dbg_sel = idx[1:0];
    #1 v = dbg_data;
  endtask

  // Runs imem from address 0; poke >= 0 pulses start again while busy.
  task automatic run_prog(input string tag, input int poke, output int cyc);
    int   msteps, mfin;
    logic prev_busy;
    model_run(400, msteps, mfin);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; prev_busy = 1'b0;
    while (!(halted || err) && cyc < 2000) begin
      prev_busy = busy;
      start = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 2000) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got no halt/err after %0d cycles", tag, cyc);
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(msteps * 3));
    check({tag, "_busy_drop"}, 32'({prev_busy, busy}), 32'b10);
    check({tag, "_end_state"}, 32'({halted, err}), (mfin == 1) ? 32'b10 : 32'b01);
    check({tag, "_fetch_left"}, 32'(exp_fetch_q.size()), 32'd0);
    check({tag, "_alu_left"}, 32'(exp_alu_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    int    op, a, b;
    int    exp_r0, exp_s, exp_g;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] v;
    int         cyc;

    vecs[0] = '{"dec_reg",   5,   3,   0, 'h002, 0, 1};
    vecs[1] = '{"dec_imm",   6,   0,   5, 'h3FF, 1, 0};
    vecs[2] = '{"xor_reg",   7,   1,   2, 'h003, 0, 0};
    vecs[3] = '{"xor_imm",   8,  -4,   3, 'h3FF, 1, 0};
    vecs[4] = '{"nand_reg",  9,   5,   3, 'h3FE, 1, 1};
    vecs[5] = '{"nand_imm", 10,  -1,  -1, 'h000, 0, 0};
    vecs[6] = '{"rot_reg",  11, -64,  63, 'h381, 1, 0};
    vecs[7] = '{"rot_imm",  12,   1,   0, 'h002, 0, 1};
    vecs[8] = '{"inc_neg",  19,  -1,   0, 'h000, 0, 0};
    vecs[9] = '{"inc_pos",  19,  63, -64, 'h040, 0, 1};

    rst_n = 1'b0; start = 1'b0; dbg_sel = 2'd0;
    clear_imem();
    do_reset();

    // Reset state.
    check("rst_busy_halted_err", 32'({busy, halted, err}), 32'd0);
    check("rst_imem", 32'({imem_rd, imem_addr}), 32'd0);
    check("rst_alu", 32'({alu_opcode, alu_op1, alu_op2}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      check("rst_reg", 32'(v), 32'd0);
    end

    // LDI R0,3; DEC R0; HALT with a start pulse while busy.
    clear_imem();
    imem[0] = enc(O_LDI, 0, 0, 3);
    imem[1] = enc(O_DEC, 0, 1, 0);
    run_prog("dec_prog", 4, cyc);
    check("dec_prog_9cyc", 32'(cyc), 32'd9);
    read_reg(0, v);
    check("dec_prog_r0", 32'(v), 32'h002);

    // Reset during EXEC of LDI R1,5.
    clear_imem();
    imem[0] = enc(O_LDI, 1, 0, 5);
    model_run(10, cyc, cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10 && dbg_state != 3'd3; i++) @(negedge clk);
    check("rst_mid_in_exec", 32'(dbg_state), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 32'({busy, halted, err, imem_rd, imem_addr}), 32'd0);
    check("rst_mid_alu", 32'({alu_opcode, alu_op1, alu_op2}), 32'd0);
    rst_n = 1'b1;
    read_reg(1, v);
    check("rst_mid_r1", 32'(v), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 4; i++) m_r[i] = 10'd0;
    m_s = 1'b0; m_g = 1'b0;
    exp_fetch_q.delete(); exp_alu_q.delete();

    // Table: each op then flags copied into R2 (s) and R3 (g) via JS/JG.
    for (int k = 0; k < 10; k++) begin
      clear_imem();
      imem[0]  = enc(O_LDI, 0, 0, vecs[k].a);
      imem[1]  = enc(O_LDI, 1, 0, vecs[k].b);
      imem[2]  = enc(vecs[k].op, 0, 1, vecs[k].b);
      imem[3]  = enc(O_LDI, 2, 0, 0);
      imem[4]  = enc(O_LDI, 3, 0, 0);
      imem[5]  = enc(O_JS, 0, 0, 7);
      imem[6]  = enc(O_JMP, 0, 0, 8);
      imem[7]  = enc(O_LDI, 2, 0, 1);
      imem[8]  = enc(O_JG, 0, 0, 10);
      imem[10] = enc(O_LDI, 3, 0, 1);
      run_prog(vecs[k].name, -1, cyc);
      read_reg(0, v); check({vecs[k].name, "_r0"}, 32'(v), 32'(vecs[k].exp_r0));
      read_reg(2, v); check({vecs[k].name, "_s"}, 32'(v), 32'(vecs[k].exp_s));
      read_reg(3, v); check({vecs[k].name, "_g"}, 32'(v), 32'(vecs[k].exp_g));
    end

    // Counted loop: DEC R2 against R3=0, JG back while the pre-decrement
    // value was positive; the pass that enters with R2=0 falls through.
    clear_imem();
    imem[0] = enc(O_LDI, 3, 0, 0);
    imem[1] = enc(O_LDI, 2, 0, 2);
    imem[2] = enc(O_DEC, 2, 3, 0);
    imem[3] = enc(O_JG, 0, 0, 2);
    run_prog("loop", -1, cyc);
    check("loop_cycles", 32'(cyc), 32'd27);
    read_reg(2, v);
    check("loop_r2", 32'(v), 32'h3FF);

    // LDI R0,-1; INC R0; LDI R1,-4; DEC R1; JS 0 taken, then JS 6 to HALT.
    do_reset();
    clear_imem();
    imem[0] = enc(O_JS, 0, 0, 6);
    imem[1] = enc(O_LDI, 0, 0, -1);
    imem[2] = enc(O_INC, 0, 0, 0);
    imem[3] = enc(O_LDI, 1, 0, -4);
    imem[4] = enc(O_DEC, 1, 0, 0);
    imem[5] = enc(O_JS, 0, 0, 0);
    run_prog("js_taken", -1, cyc);
    check("js_taken_cycles", 32'(cyc), 32'd24);
    read_reg(0, v); check("js_taken_r0", 32'(v), 32'h000);
    read_reg(1, v); check("js_taken_r1", 32'(v), 32'h3FB);

    // pc wrap: JMP 127; NOP at 127 -> next fetch at 0.
    do_reset();
    clear_imem();
    imem[0]   = enc(O_JS, 0, 0, 4);
    imem[1]   = enc(O_DECI, 0, 0, 0);
    imem[2]   = enc(O_JMP, 0, 0, 127);
    imem[127] = enc(O_NOP, 0, 0, 0);
    run_prog("wrap", -1, cyc);
    check("wrap_cycles", 32'(cyc), 32'd18);
    read_reg(0, v); check("wrap_r0", 32'(v), 32'h3FF);

    // Illegal opcode 11000 -> ERR, then restart from ERR at pc 0.
    clear_imem();
    imem[0] = enc(O_LDI, 0, 0, 7);
    imem[1] = enc(24, 1, 0, 5);
    run_prog("illegal", -1, cyc);
    check("illegal_flags", 32'({err, busy, halted}), 32'b100);
    check("illegal_state", 32'(dbg_state), 32'd5);
    read_reg(0, v); check("illegal_r0", 32'(v), 32'd7);
    read_reg(1, v); check("illegal_r1", 32'(v), 32'd0);
    imem[1] = enc(O_LDI, 0, 0, 9);
    run_prog("restart", -1, cyc);
    check("restart_flags", 32'({err, busy, halted}), 32'b001);
    read_reg(0, v); check("restart_r0", 32'(v), 32'd9);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
